execute_stage: RTL and testbench
================================

# execute_stage

Execute/write-back stage of the 8-bit pipeline. It accepts a decoded instruction with both operands already read (and forwarded) from the register file, and computes the ALU result. It then drives the register-file write port (`readWrite`, `target`, `writeData`) one cycle later. Single-cycle ops complete in one cycle; MUL runs an iterative 8-cycle shift-add and stalls the upstream decode stage while it runs.

## Interface
- `WIDTH`, default 8: datapath width. Only 8 is supported.
- `MUL_CYCLES`, default 8: iteration count of the multiplier. Must equal `WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  decode presents an instruction this cycle.
- `opcode`  in  4  operation, encoding in `cpu_pkg`.
- `dst`  in  3  destination register index.
- `dataA`, `dataB`  in  8 each  operands from the register file.
- `imm`  in  8  immediate.
- `stall`  out  1  upstream must hold its instruction; `valid_in` is ignored while high.
- `readWrite`  out  1  register-file write enable, 1 = write.
- `target`  out  3  register-file write index.
- `writeData`  out  8  register-file write data.
- `zero`, `carry`  out  1 each  flags from the last writing op.

## Operation
- Opcodes:
  - 0 NOP: no write.
  - 1 ADD: A+B.
  - 2 SUB: A−B.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL: A<<1.
  - 7 SHR: A>>1, logical.
  - 8 ADDI: A+imm.
  - 9 LI: imm.
  - 10 MUL: low 8 bits of A×B.
  - 11–15: treated as NOP.
- Arithmetic is 9-bit internally; the result is the low 8 bits.
- `carry` is set as follows:
  - ADD/ADDI: bit 8 of the sum.
  - SUB: borrow, i.e. A<B.
  - SHL: old A[7].
  - SHR: old A[0].
  - MUL: 1 if the high product byte is nonzero.
  - Logic ops and LI: 0.
- `zero` = (result == 0).
- Flags update only on an op that issues a write.
- `readWrite` is asserted only when the op writes and `dst != 0`. Writes to r0 are dropped here and flags do not update.
- FSM states:
  - IDLE: the accept condition is `valid_in && !stall`. Accepting a single-cycle op registers its result. Accepting MUL latches A and B, clears the accumulator and counter, and moves to MUL.
  - MUL: each cycle, if multiplier bit0 is 1, the accumulator adds the multiplicand. The multiplicand shifts left and the multiplier shifts right, and the counter increments. At counter = `MUL_CYCLES`−1 the final step completes, the result registers are written, and the FSM returns to IDLE.
- `stall` = (state == MUL). It is combinational from the state register.

## Timing
- Reset values: `readWrite`=0, `target`=0, `writeData`=0, `zero`=0, `carry`=0, `stall`=0, state IDLE, counter 0.
- Single-cycle op accepted in cycle N:
  - `readWrite`/`target`/`writeData` are valid during N+1 only.
  - The register file commits at the end of N+1.
  - `readWrite` returns to 0 in N+2 unless another op is accepted in N+1.
- Back-to-back ops: one accept per cycle. The output registers reload every cycle.
- MUL accepted in cycle N:
  - `stall` is high in cycles N+1..N+8.
  - Result is valid in cycle N+9 for one cycle, and `stall` is low in N+9.
  - A new op may be accepted in N+9.
- `valid_in` while `stall` is high is ignored. Upstream holds; no instruction is lost or duplicated.
- During MUL, `readWrite` is 0. The write from the op accepted at N is still emitted in N+1 only if that op was single-cycle.
- `rst` during MUL aborts: the next cycle is IDLE, all outputs are at their reset values, and no partial write is issued.
- `rst` has priority over `valid_in` in the same cycle.

## Structure
- `cpu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_MUL`),
  - `REG_IDX_W`=3,
  - `DATA_W`=8.
- The decode stage and the register file import the same package.
- One sub-module, `mul8_seq`, is the shift-add core. It has ports: start, A, B, done, product[15:0], busy.
- `execute_stage` owns the FSM, the ALU mux, the flags, and the output registers.

## Test plan
- Reset, then ADD: dst=3, A=0xF0, B=0x20 → in N+1 `readWrite`=1, `target`=3, `writeData`=0x10, `carry`=1, `zero`=0.
- SUB: dst=2, A=5, B=5, then XOR: dst=4, A=0xAA, B=0x0F, issued back-to-back → N+1: 0x00 with `zero`=1, `carry`=0; N+2: 0xA5 with `zero`=0.
- ADD with dst=0, A=1, B=1 → `readWrite` stays 0; flags keep their previous values.
- MUL: dst=5, A=13, B=11, with decode holding `valid_in`=1 → `stall` high for exactly 8 cycles, then `writeData`=0x8F, `carry`=0. A second MUL 0x10×0x10 → 0x00, `zero`=1, `carry`=1.
- MUL accepted, `rst` pulsed in the 4th stall cycle → next cycle `stall`=0 and all outputs 0. No write appears afterward.
- SHR: A=0x01 → `writeData`=0x00, `carry`=1, `zero`=1. LI: imm=0x7E, dst=7 → `writeData`=0x7E.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: datapath widths and opcode encoding.
// Imported by decode, register file and execute stages.
package cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OPCODE_W  = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_LI   = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd10;

  // Opcodes 11-15 are reserved and behave as NOP.
  function automatic logic opWrites(logic [OPCODE_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/mul8_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, MUL_CYCLES cycles per product.
// product is the finished result only in the cycle where done is high.
module mul8_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [2*WIDTH-1:0] mcandQ;
  logic [2*WIDTH-1:0] accQ;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   mplierQ;
  logic [CntW-1:0]    countQ;
  logic               busyQ;

  always_comb begin
    addend  = mplierQ[0] ? mcandQ : '0;
    accNext = accQ + addend;
    done    = busyQ && (countQ == CntW'(MUL_CYCLES - 1));
    product = accNext;
    busy    = busyQ;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcandQ  <= '0;
      accQ    <= '0;
      mplierQ <= '0;
      countQ  <= '0;
      busyQ   <= 1'b0;
    end else if (start) begin
      mcandQ  <= {{WIDTH{1'b0}}, A};
      accQ    <= '0;
      mplierQ <= B;
      countQ  <= '0;
      busyQ   <= 1'b1;
    end else if (busyQ) begin
      accQ    <= accNext;
      mcandQ  <= mcandQ << 1;
      mplierQ <= mplierQ >> 1;
      countQ  <= countQ + 1'b1;
      if (done) busyQ <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute/write-back stage: single-cycle ALU plus sequential MUL, driving the
// register-file write port one cycle after an instruction is accepted.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_IDX_W-1:0] dst,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  input  logic [WIDTH-1:0]     imm,
  output logic                 stall,
  output logic                 readWrite,
  output logic [REG_IDX_W-1:0] target,
  output logic [WIDTH-1:0]     writeData,
  output logic                 zero,
  output logic                 carry
);

  typedef enum logic [0:0] {StIdle, StMul} execStateT;

  execStateT stateQ, stateD;

  logic                 readWriteQ, readWriteD;
  logic [REG_IDX_W-1:0] targetQ, targetD;
  logic [WIDTH-1:0]     writeDataQ, writeDataD;
  logic                 zeroQ, zeroD;
  logic                 carryQ, carryD;
  logic [REG_IDX_W-1:0] mulDstQ;

  logic                 accept;
  logic                 mulStart;
  logic                 mulDone;
  logic                 mulBusy;
  logic [2*WIDTH-1:0]   mulProduct;
  logic [WIDTH:0]       aluRes;
  logic                 aluCarry;

  mul8_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (mulStart),
    .A       (dataA),
    .B       (dataB),
    .done    (mulDone),
    .product (mulProduct),
    .busy    (mulBusy)
  );

  assign stall  = (stateQ == StMul);
  assign accept = valid_in && !stall;

  // 9-bit ALU; bit WIDTH carries out/borrow for the arithmetic ops.
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    case (opcode)
      OP_ADD: begin
        aluRes   = {1'b0, dataA} + {1'b0, dataB};
        aluCarry = aluRes[WIDTH];
      end
      OP_SUB: begin
        aluRes   = {1'b0, dataA} - {1'b0, dataB};
        aluCarry = aluRes[WIDTH];
      end
      OP_AND: aluRes = {1'b0, dataA & dataB};
      OP_OR:  aluRes = {1'b0, dataA | dataB};
      OP_XOR: aluRes = {1'b0, dataA ^ dataB};
      OP_SHL: begin
        aluRes   = {1'b0, dataA[WIDTH-2:0], 1'b0};
        aluCarry = dataA[WIDTH-1];
      end
      OP_SHR: begin
        aluRes   = {2'b00, dataA[WIDTH-1:1]};
        aluCarry = dataA[0];
      end
      OP_ADDI: begin
        aluRes   = {1'b0, dataA} + {1'b0, imm};
        aluCarry = aluRes[WIDTH];
      end
      OP_LI:   aluRes = {1'b0, imm};
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    stateD     = stateQ;
    readWriteD = 1'b0;
    targetD    = targetQ;
    writeDataD = writeDataQ;
    zeroD      = zeroQ;
    carryD     = carryQ;
    mulStart   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mulStart = 1'b1;
            stateD   = StMul;
          end else if (opWrites(opcode) && (dst != '0)) begin
            readWriteD = 1'b1;
            targetD    = dst;
            writeDataD = aluRes[WIDTH-1:0];
            zeroD      = (aluRes[WIDTH-1:0] == '0);
            carryD     = aluCarry;
          end
        end
      end
      StMul: begin
        if (mulDone) begin
          stateD = StIdle;
          if (mulDstQ != '0) begin
            readWriteD = 1'b1;
            targetD    = mulDstQ;
            writeDataD = mulProduct[WIDTH-1:0];
            zeroD      = (mulProduct[WIDTH-1:0] == '0);
            carryD     = |mulProduct[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= StIdle;
      readWriteQ <= 1'b0;
      targetQ    <= '0;
      writeDataQ <= '0;
      zeroQ      <= 1'b0;
      carryQ     <= 1'b0;
      mulDstQ    <= '0;
    end else begin
      stateQ     <= stateD;
      readWriteQ <= readWriteD;
      targetQ    <= targetD;
      writeDataQ <= writeDataD;
      zeroQ      <= zeroD;
      carryQ     <= carryD;
      if (mulStart) mulDstQ <= dst;
    end
  end

  assign readWrite = readWriteQ;
  assign target    = targetQ;
  assign writeData = writeDataQ;
  assign zero      = zeroQ;
  assign carry     = carryQ;

  // The FSM and the multiplier core must agree on when a product is in flight.
  assert property (@(posedge clk) disable iff (rst) (stateQ == StMul) == mulBusy);

endmodule

// File: tb/tb_execute_stage.sv
// Directed test-plan scenarios plus randomized traffic against a cycle-indexed reference model.
module tb_execute_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [3:0] opcode;
  logic [2:0] dst;
  logic [7:0] dataA, dataB, imm;
  logic       stall, readWrite;
  logic [2:0] target;
  logic [7:0] writeData;
  logic       zero, carry;

  execute_stage #(
    .WIDTH      (8),
    .MUL_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .opcode    (opcode),
    .dst       (dst),
    .dataA     (dataA),
    .dataB     (dataB),
    .imm       (imm),
    .stall     (stall),
    .readWrite (readWrite),
    .target    (target),
    .writeData (writeData),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  // Reference model state: absolute cycle of the last accepted MUL and its operands.
  int mulAcc = -1000;
  int mulA, mulB, mulDst;
  bit expRw, expZero, expCarry, checkAll;
  int expTarget, expData;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void refAlu(input int op, input int a, input int b, input int im,
                                 output bit wr, output int res, output bit cy);
    wr  = 1'b1;
    cy  = 1'b0;
    res = 0;
    case (op)
      1:  begin res = a + b;  cy = (res > 255); end
      2:  begin res = a - b;  cy = (a < b);     end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  begin res = a * 2;  cy = (a >= 128);  end
      7:  begin res = a / 2;  cy = ((a % 2) == 1); end
      8:  begin res = a + im; cy = (res > 255); end
      9:  res = im;
      10: begin res = a * b;  cy = (res > 255); end
      default: wr = 1'b0;
    endcase
    res = res & 255;
  endfunction

  task automatic applyWrite(input int op, input int a, input int b, input int im, input int d);
    bit wr, cy;
    int res;
    refAlu(op, a, b, im, wr, res, cy);
    if (wr && d != 0) begin
      expRw     = 1'b1;
      expTarget = d;
      expData   = res;
      expZero   = (res == 0);
      expCarry  = cy;
    end
  endtask

  // Present one cycle of inputs, advance the model, clock, then check next-cycle outputs.
  task automatic step(input bit r, input bit v, input int op, input int d,
                      input int a, input int b, input int im);
    bit stallNow;
    rst      = r;
    valid_in = v;
    opcode   = op[3:0];
    dst      = d[2:0];
    dataA    = a[7:0];
    dataB    = b[7:0];
    imm      = im[7:0];
    stallNow = (cyc >= mulAcc + 1) && (cyc <= mulAcc + 8);
    #1;
    checkVal("stall", stall, stallNow);
    expRw    = 1'b0;
    checkAll = 1'b0;
    if (r) begin
      expTarget = 0;
      expData   = 0;
      expZero   = 1'b0;
      expCarry  = 1'b0;
      mulAcc    = -1000;
      checkAll  = 1'b1;
    end else if (cyc == mulAcc + 8) begin
      applyWrite(10, mulA, mulB, 0, mulDst);
    end else if (!stallNow && v) begin
      if (op == 10) begin
        mulAcc = cyc;
        mulA   = a & 255;
        mulB   = b & 255;
        mulDst = d & 7;
      end else begin
        applyWrite(op, a & 255, b & 255, im & 255, d & 7);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    checkVal("readWrite", readWrite, expRw);
    checkVal("zero", zero, expZero);
    checkVal("carry", carry, expCarry);
    if (expRw || checkAll) begin
      checkVal("target", target, expTarget);
      checkVal("writeData", writeData, expData);
    end
  endtask

  initial begin
    int op;
    rst = 1'b1; valid_in = 1'b0; opcode = '0; dst = '0;
    dataA = '0; dataB = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstStall", stall, 0);
    checkVal("rstReadWrite", readWrite, 0);
    checkVal("rstTarget", target, 0);
    checkVal("rstWriteData", writeData, 0);
    checkVal("rstZero", zero, 0);
    checkVal("rstCarry", carry, 0);

    step(0, 1, OP_ADD, 3, 'hF0, 'h20, 0);
    checkVal("addData", writeData, 8'h10);
    checkVal("addCarry", carry, 1);
    checkVal("addTarget", target, 3);

    step(0, 1, OP_SUB, 2, 5, 5, 0);
    checkVal("subData", writeData, 8'h00);
    checkVal("subZero", zero, 1);
    step(0, 1, OP_XOR, 4, 'hAA, 'h0F, 0);
    checkVal("xorData", writeData, 8'hA5);
    checkVal("xorZero", zero, 0);

    step(0, 1, OP_ADD, 0, 1, 1, 0);
    checkVal("r0NoWrite", readWrite, 0);

    step(0, 1, OP_MUL, 5, 13, 11, 0);
    repeat (8) step(0, 1, OP_MUL, 6, 'h10, 'h10, 0);
    checkVal("mulData", writeData, 8'h8F);
    checkVal("mulCarry", carry, 0);
    step(0, 1, OP_MUL, 6, 'h10, 'h10, 0);
    repeat (8) step(0, 1, OP_SHR, 1, 1, 0, 0);
    checkVal("mul2Data", writeData, 8'h00);
    checkVal("mul2Zero", zero, 1);
    checkVal("mul2Carry", carry, 1);
    step(0, 1, OP_SHR, 1, 1, 0, 0);
    checkVal("shrCarry", carry, 1);
    step(0, 1, OP_LI, 7, 0, 0, 'h7E);
    checkVal("liData", writeData, 8'h7E);

    // Abort a MUL with reset in its 4th stall cycle.
    step(0, 1, OP_MUL, 3, 200, 3, 0);
    repeat (3) step(0, 1, OP_ADD, 2, 1, 2, 0);
    step(1, 1, OP_ADD, 2, 1, 2, 0);
    checkVal("abortStall", stall, 0);
    repeat (10) step(0, 0, OP_NOP, 0, 0, 0, 0);

    repeat (400) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) op = OP_MUL;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), op,
           $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
